// File: rtl/segasys1_hs_pkg.sv
// Shared types and limits for the host-to-region access bridge.
`timescale 1ns/1ps
package segasys1_hs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    DECODE,
    WRITE,
    RWAIT,
    DONE
  } hs_state_e;

  localparam int MAX_RDLAT = 4;
  localparam int MAX_NREG  = 8;

  // Region 0 answers to tag D, region 1 to tag C.
  localparam logic [7:0] DEF_TAGS = 8'hCD;

endpackage

// File: rtl/segasys1_hs_decode.sv
// Tag match to one-hot region select; lowest matching index wins.
// Purely combinational, no latency, no flow control.
`timescale 1ns/1ps
module segasys1_hs_decode
  import segasys1_hs_pkg::*;
#(
  parameter int NREG = 2,
  parameter int TAGW = 4,
  parameter logic [NREG*TAGW-1:0] TAGS = DEF_TAGS
) (
  input  logic [TAGW-1:0] tag,
  output logic [NREG-1:0] sel,
  output logic            hit
);

  always_comb begin
    sel = '0;
    hit = 1'b0;
    // Scan downwards so the lowest matching index overrides the rest.
    for (int i = NREG - 1; i >= 0; i--) begin
      if (tag == TAGS[i*TAGW +: TAGW]) begin
        sel    = '0;
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/segasys1_hsbridge.sv
// Host bridge into paused-core memory regions; write 4 cycles, read 3+RDLAT once PAUSED.
// Stalls in HOLD until PAUSED; optional unmapped-access counter via SEGASYS1_HSBR_ERRCNT_EN.
`timescale 1ns/1ps
module segasys1_hsbridge
  import segasys1_hs_pkg::*;
#(
  parameter int NREG  = 2,
  parameter int AW    = 16,
  parameter int DW    = 8,
  parameter int TAGW  = 4,
  parameter int RDLAT = 1,
  parameter logic [NREG*TAGW-1:0] TAGS = DEF_TAGS
) (
  input  logic               CLK40M,
  input  logic               RESET_N,
  input  logic               HS_REQ,
  input  logic               HS_WR,
  input  logic [AW-1:0]      HSAD,
  input  logic [DW-1:0]      HSDI,
  output logic [DW-1:0]      HSDO,
  output logic               HS_ACK,
  output logic               HS_ERR,
  output logic               PAUSE_REQ,
  input  logic               PAUSED,
  output logic [AW-1:0]      RG_AD,
  output logic [DW-1:0]      RG_DO,
  output logic [NREG-1:0]    RG_WE,
  output logic [NREG-1:0]    RG_RE,
  input  logic [NREG*DW-1:0] RG_DI
`ifdef SEGASYS1_HSBR_ERRCNT_EN
  ,
  output logic [7:0]         ERRCNT
`endif
);

  localparam int CNTW = $clog2(MAX_RDLAT);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(RDLAT - 1);

  hs_state_e       state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic            wr_q, wr_d;
  logic [NREG-1:0] sel_q, sel_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   hsdo_q, hsdo_d;
  logic            pause_q, pause_d;
  logic [NREG-1:0] dec_sel;
  logic            dec_hit;
  logic [DW-1:0]   rd_dat;
`ifdef SEGASYS1_HSBR_ERRCNT_EN
  logic [7:0]      errcnt_q, errcnt_d;
`endif

  segasys1_hs_decode #(
    .NREG (NREG),
    .TAGW (TAGW),
    .TAGS (TAGS)
  ) u_decode (
    .tag (addr_q[AW-1 -: TAGW]),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel_q[i]) rd_dat = rd_dat | RG_DI[i*DW +: DW];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    hsdo_d  = hsdo_q;
    pause_d = pause_q;
`ifdef SEGASYS1_HSBR_ERRCNT_EN
    errcnt_d = errcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        pause_d = HS_REQ;
        if (HS_REQ) begin
          addr_d  = HSAD;
          wdat_d  = HSDI;
          wr_d    = HS_WR;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (PAUSED) state_d = DECODE;
      end
      DECODE: begin
        sel_d = dec_sel;
        err_d = !dec_hit;
        cnt_d = '0;
        if (!dec_hit) begin
          state_d = DONE;
          if (!wr_q) hsdo_d = '1;
`ifdef SEGASYS1_HSBR_ERRCNT_EN
          if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
`endif
        end else if (wr_q) begin
          state_d = WRITE;
        end else begin
          state_d = RWAIT;
        end
      end
      WRITE: begin
        state_d = DONE;
      end
      RWAIT: begin
        if (cnt_q == CNT_LAST) begin
          hsdo_d  = rd_dat;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // A still-asserted request keeps the core frozen for the next access.
        pause_d = HS_REQ;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK40M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      hsdo_q  <= '0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      hsdo_q  <= hsdo_d;
      pause_q <= pause_d;
    end
  end

`ifdef SEGASYS1_HSBR_ERRCNT_EN
  always_ff @(posedge CLK40M or negedge RESET_N) begin
    if (!RESET_N) errcnt_q <= '0;
    else          errcnt_q <= errcnt_d;
  end

  assign ERRCNT = errcnt_q;
`endif

  assign HSDO      = hsdo_q;
  assign HS_ACK    = (state_q == DONE);
  assign HS_ERR    = (state_q == DONE) && err_q;
  assign PAUSE_REQ = pause_q;
  assign RG_AD     = addr_q;
  assign RG_DO     = wdat_q;
  assign RG_WE     = (state_q == WRITE) ? sel_q : '0;
  assign RG_RE     = (state_q == RWAIT) ? sel_q : '0;

endmodule

// File: tb/tb_segasys1_hsbridge.sv
// Randomized bench for segasys1_hsbridge against a transaction-level region/latency model.
`timescale 1ns/1ps
module tb_segasys1_hsbridge;

  localparam int RDLAT = 3;

  logic        CLK40M = 1'b0;
  logic        RESET_N;
  logic        HS_REQ;
  logic        HS_WR;
  logic [15:0] HSAD;
  logic [7:0]  HSDI;
  logic [7:0]  HSDO;
  logic        HS_ACK;
  logic        HS_ERR;
  logic        PAUSE_REQ;
  logic        PAUSED;
  logic [15:0] RG_AD;
  logic [7:0]  RG_DO;
  logic [1:0]  RG_WE;
  logic [1:0]  RG_RE;
  logic [15:0] RG_DI;
`ifdef SEGASYS1_HSBR_ERRCNT_EN
  logic [7:0]  ERRCNT;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] ref_mem [2][256];
  logic [7:0] hsdo_model;
  int         errcnt_model;

  bit [7:0] env_wr  [2][256];
  bit       env_vld [2][256];

  segasys1_hsbridge #(.RDLAT(RDLAT)) dut (
    .CLK40M    (CLK40M),
    .RESET_N   (RESET_N),
    .HS_REQ    (HS_REQ),
    .HS_WR     (HS_WR),
    .HSAD      (HSAD),
    .HSDI      (HSDI),
    .HSDO      (HSDO),
    .HS_ACK    (HS_ACK),
    .HS_ERR    (HS_ERR),
    .PAUSE_REQ (PAUSE_REQ),
    .PAUSED    (PAUSED),
    .RG_AD     (RG_AD),
    .RG_DO     (RG_DO),
    .RG_WE     (RG_WE),
    .RG_RE     (RG_RE),
    .RG_DI     (RG_DI)
`ifdef SEGASYS1_HSBR_ERRCNT_EN
    ,
    .ERRCNT    (ERRCNT)
`endif
  );

  always #5 CLK40M = ~CLK40M;

  function automatic logic [7:0] init_val(input int r, input int a);
    return 8'(a * 7 + r * 53 + 17);
  endfunction

  // Region memories seen by the bridge: written bytes, else a fixed fill pattern.
  always @(posedge CLK40M) begin
    for (int i = 0; i < 2; i++) begin
      if (RG_WE[i]) begin
        env_wr[i][RG_AD[7:0]]  <= RG_DO;
        env_vld[i][RG_AD[7:0]] <= 1'b1;
      end
    end
  end

  always_comb begin
    RG_DI = '0;
    for (int i = 0; i < 2; i++)
      RG_DI[i*8 +: 8] = env_vld[i][RG_AD[7:0]] ? env_wr[i][RG_AD[7:0]] : init_val(i, int'(RG_AD[7:0]));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int region_of(input logic [3:0] t);
    if (t == 4'hD) return 0;
    if (t == 4'hC) return 1;
    return -1;
  endfunction

  // One host access; pdly = negedge index at which PAUSED rises (0 = already high).
  task automatic do_access(input bit wr, input logic [15:0] addr, input logic [7:0] dat,
                           input int pdly, input bit keep, input bit early_drop, input bit mid_drop);
    int r, cyc, lat, exp_lat, we_n, re_n, bad, pr_bad;
    logic [1:0] we_m, re_m;
    logic [7:0] exp_do;
    r = region_of(addr[15:12]);
    exp_lat = (pdly > 1) ? pdly : 1;
    if (r < 0)   exp_lat += 2;
    else if (wr) exp_lat += 3;
    else         exp_lat += 2 + RDLAT;
    exp_do = (r < 0) ? 8'hFF : ref_mem[r][addr[7:0]];
    PAUSED = (pdly == 0);
    HS_REQ = 1'b1; HS_WR = wr; HSAD = addr; HSDI = dat;
    cyc = 0; lat = -1; we_n = 0; re_n = 0; bad = 0; pr_bad = 0; we_m = '0; re_m = '0;
    while (cyc < 64 && lat < 0) begin
      @(negedge CLK40M);
      cyc++;
      if (!PAUSE_REQ) pr_bad++;
      if (HS_ACK) begin
        lat = cyc;
      end else begin
        if (|RG_WE) begin we_n++; we_m = we_m | RG_WE; end
        if (|RG_RE) begin re_n++; re_m = re_m | RG_RE; end
        if (!$onehot0(RG_WE) || !$onehot0(RG_RE) || ((|RG_WE) && (|RG_RE))) bad++;
        if (pdly > 0 && cyc == pdly) PAUSED = 1'b1;
        if (early_drop && cyc == 1) HS_REQ = 1'b0;
        if (mid_drop && cyc == 3) PAUSED = 1'b0;
      end
    end
    check("ack_latency", 32'(lat), 32'(exp_lat));
    check("hs_err", 32'(HS_ERR), 32'(r < 0));
    if (!wr) check("hsdo_read", 32'(HSDO), 32'(exp_do));
    check("we_cycles", 32'(we_n), (wr && r >= 0) ? 32'd1 : 32'd0);
    check("we_region", 32'(we_m), (wr && r >= 0) ? (32'd1 << r) : 32'd0);
    check("re_cycles", 32'(re_n), (!wr && r >= 0) ? 32'(RDLAT) : 32'd0);
    check("re_region", 32'(re_m), (!wr && r >= 0) ? (32'd1 << r) : 32'd0);
    check("strobe_excl", 32'(bad), 32'd0);
    check("pause_held", 32'(pr_bad), 32'd0);
    if (wr && r >= 0) ref_mem[r][addr[7:0]] = dat;
    if (!wr) hsdo_model = exp_do;
    if (r < 0 && errcnt_model < 255) errcnt_model++;
`ifdef SEGASYS1_HSBR_ERRCNT_EN
    check("errcnt", 32'(ERRCNT), 32'(errcnt_model));
`endif
    if (!keep) HS_REQ = 1'b0;
    @(negedge CLK40M);
    check("ack_pulse", 32'(HS_ACK), 32'd0);
    check("pause_after", 32'(PAUSE_REQ), 32'(keep));
    check("hsdo_hold", 32'(HSDO), 32'(hsdo_model));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, ack_seen;
    for (int r = 0; r < 2; r++)
      for (int a = 0; a < 256; a++) ref_mem[r][a] = init_val(r, a);
    hsdo_model = 8'h00; errcnt_model = 0;
    RESET_N = 1'b0; HS_REQ = 1'b0; HS_WR = 1'b0; HSAD = '0; HSDI = '0; PAUSED = 1'b0;
    repeat (3) @(negedge CLK40M);
    check("rst_hsdo", 32'(HSDO), 32'd0);
    check("rst_ack", 32'(HS_ACK), 32'd0);
    check("rst_err", 32'(HS_ERR), 32'd0);
    check("rst_pause", 32'(PAUSE_REQ), 32'd0);
    check("rst_we_re", 32'({RG_WE, RG_RE}), 32'd0);
    check("rst_ad_do", 32'({RG_AD, RG_DO}), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK40M);

    // Directed cases.
    do_access(1'b1, 16'hC010, 8'h5A, 0, 1'b0, 1'b0, 1'b0);
    check("c010_written", 32'(env_wr[1][8'h10]), 32'h5A);
    do_access(1'b1, 16'hD123, 8'hA5, 0, 1'b0, 1'b0, 1'b0);
    do_access(1'b0, 16'hD123, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    do_access(1'b0, 16'h8000, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    do_access(1'b1, 16'hC044, 8'h3C, 10, 1'b0, 1'b0, 1'b0);
    do_access(1'b1, 16'hC001, 8'h77, 0, 1'b0, 1'b0, 1'b0);
    do_access(1'b0, 16'hD123, 8'h00, 0, 1'b1, 1'b0, 1'b0);
    do_access(1'b0, 16'hC001, 8'h00, 0, 1'b1, 1'b0, 1'b0);
    do_access(1'b0, 16'hC010, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    do_access(1'b0, 16'hD020, 8'h00, 0, 1'b0, 1'b1, 1'b0);
    do_access(1'b0, 16'hD021, 8'h00, 0, 1'b0, 1'b0, 1'b1);
    do_access(1'b1, 16'hC022, 8'h99, 4, 1'b0, 1'b0, 1'b0);

    // Randomized accesses.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] tg;
      logic [15:0] ad;
      bit wr, kp, ed, md;
      int pd, sel;
      sel = $urandom_range(0, 9);
      tg = (sel < 4) ? 4'hD : (sel < 8) ? 4'hC : 4'($urandom_range(0, 15));
      ad = {tg, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
      wr = $urandom_range(0, 1) == 1;
      pd = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 6) : 0;
      kp = (i != 149) && ($urandom_range(0, 3) == 0);
      ed = !kp && ($urandom_range(0, 4) == 0);
      md = (pd == 0) && (region_of(tg) >= 0) && ($urandom_range(0, 4) == 0);
      do_access(wr, ad, 8'($urandom), pd, kp, ed, md);
    end

    // Reset in the middle of a read wait.
    PAUSED = 1'b1; HS_REQ = 1'b1; HS_WR = 1'b0; HSAD = 16'hD005;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge CLK40M);
      if (|RG_RE) seen = 1;
    end
    check("rst_re_seen", 32'(seen), 32'd1);
    HS_REQ = 1'b0;
    @(negedge CLK40M);
    RESET_N = 1'b0;
    #1;
    check("rst_mid_pause", 32'(PAUSE_REQ), 32'd0);
    check("rst_mid_re", 32'(RG_RE), 32'd0);
    check("rst_mid_ack", 32'(HS_ACK), 32'd0);
    check("rst_mid_hsdo", 32'(HSDO), 32'd0);
    ack_seen = 0;
    repeat (3) begin @(negedge CLK40M); ack_seen = ack_seen | int'(HS_ACK); end
    RESET_N = 1'b1;
    repeat (6) begin @(negedge CLK40M); ack_seen = ack_seen | int'(HS_ACK); end
    check("rst_no_ack", 32'(ack_seen), 32'd0);
    check("rst_idle_pause", 32'(PAUSE_REQ), 32'd0);
    hsdo_model = 8'h00; errcnt_model = 0;

    do_access(1'b0, 16'hC010, 8'h00, 0, 1'b0, 1'b0, 1'b0);
`ifdef SEGASYS1_HSBR_ERRCNT_EN
    for (int i = 0; i < 260; i++) do_access(1'b0, 16'h8000 | 16'(i), 8'h00, 0, 1'b0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
